// File: rtl/mux_nx1_rr_stage.sv
// N:1 channel multiplexer with a single registered output stage.
// Channel choice is either a fixed select or round-robin arbitration.
// The output register is valid/ready handshaked, so a new word can load
// in the same cycle the held word is consumed (full throughput).
module mux_nx1_rr_stage #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          s,
   input  logic [CHANNELS*WIDTH-1:0] a,
   input  logic [CHANNELS-1:0]       a_valid,
   output logic [CHANNELS-1:0]       a_ready,
   output logic [WIDTH-1:0]          y,
   output logic                      y_valid,
   input  logic                      y_ready,
   output logic [SEL_W-1:0]          y_chan
);

   // Output stage state and round-robin pointer
   logic [WIDTH-1:0] y_p1;
   logic [SEL_W-1:0] chan_p1;
   logic             vld_p1;
   logic [SEL_W-1:0] ptr;

   // Stage 0 arbitration results
   logic             reg_free_p0;
   logic             gnt_vld_p0;
   logic [SEL_W-1:0] gnt_idx_p0;
   logic [WIDTH-1:0] gnt_data_p0;
   logic             xfer_p0;
   logic [SEL_W-1:0] ptr_nxt;

   // ---------------- stage 0: grant selection (combinational) ----------------

   // Pick the candidate channel: fixed select or first valid at/after ptr
   always_comb begin
      int  cand;
      logic found;
      gnt_vld_p0 = 1'b0;
      gnt_idx_p0 = '0;
      cand       = 0;
      found      = 1'b0;
      if (!mode) begin
         // Selects beyond the channel count never grant
         if ((int'(s) < CHANNELS) && a_valid[s]) begin
            gnt_vld_p0 = 1'b1;
            gnt_idx_p0 = s;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            cand = int'(ptr) + i;
            if (cand >= CHANNELS) begin
               cand = cand - CHANNELS;
            end
            if (!found && a_valid[cand]) begin
               found      = 1'b1;
               gnt_vld_p0 = 1'b1;
               gnt_idx_p0 = SEL_W'(cand);
            end
         end
      end
   end

   // Handshake: register may accept when empty or being drained this cycle
   always_comb begin
      reg_free_p0 = !vld_p1 || y_ready;
      xfer_p0     = reg_free_p0 && gnt_vld_p0 && !rst;
      a_ready     = xfer_p0 ? (CHANNELS'(1) << gnt_idx_p0) : '0;
      gnt_data_p0 = a[int'(gnt_idx_p0)*WIDTH +: WIDTH];
      ptr_nxt     = (gnt_idx_p0 == SEL_W'(CHANNELS-1)) ? '0 : gnt_idx_p0 + SEL_W'(1);
   end

   // ---------------- stage 1: output register ----------------

   // Load granted word, drop valid when nothing granted, hold under backpressure
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1  <= 1'b0;
         y_p1    <= '0;
         chan_p1 <= '0;
         ptr     <= '0;
      end else if (reg_free_p0) begin
         vld_p1 <= xfer_p0;
         if (xfer_p0) begin
            y_p1    <= gnt_data_p0;
            chan_p1 <= gnt_idx_p0;
            // Only round-robin transfers advance the fairness pointer
            if (mode) begin
               ptr <= ptr_nxt;
            end
         end
      end
   end

   assign y       = y_p1;
   assign y_chan  = chan_p1;
   assign y_valid = vld_p1;

endmodule
